neogeo_tx_gen: RTL and testbench



---
 rtl/neogeo_tx_gen.sv | 191 +++++++++++++++++++
 tb/tb_neogeo_tx_gen.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neogeo_tx_gen.sv
// NeoGeo LSPC-style video source: raster counters, test patterns and XOR composite sync.
// Every output is registered one cycle after the counter state that produced it.
module neogeo_tx_gen #(
    parameter int H_TOTAL  = 384,
    parameter int H_SYNC   = 29,
    parameter int H_START  = 60,
    parameter int H_ACTIVE = 320,
    parameter int V_TOTAL  = 264,
    parameter int V_SYNC   = 8,
    parameter int V_START  = 24,
    parameter int V_ACTIVE = 224
) (
    input  logic       VCLK_i,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    input  logic       dark_i,
    input  logic       shadow_i,
    output logic [4:0] R_o,
    output logic [4:0] G_o,
    output logic [4:0] B_o,
    output logic       DARK_o,
    output logic       SHADOW_o,
    output logic       CSYNC_o,
    output logic       frame_start_o,
    output logic [7:0] frame_cnt_o
);
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_SYNC_W = 9'(H_SYNC);
    localparam logic [8:0] V_SYNC_W = 9'(V_SYNC);
    localparam logic [8:0] H_BEG    = 9'(H_START);
    localparam logic [8:0] H_END    = 9'(H_START + H_ACTIVE);
    localparam logic [8:0] V_BEG    = 9'(V_START);
    localparam logic [8:0] V_END    = 9'(V_START + V_ACTIVE);
    localparam logic [5:0] BAR_LAST = 6'd39;

    logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d, fcnt_out_q, fcnt_out_d;
    logic [1:0] pat_q, pat_d;
    logic [2:0] bar_q, bar_d;
    logic [5:0] bar_px_q, bar_px_d;
    logic [4:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       dark_q, dark_d, shadow_q, shadow_d, csync_q, csync_d, fstart_q, fstart_d;

    logic       hs, vs, h_act, active, frame_wrap, box;
    logic [8:0] x;
    logic [7:0] y;
    logic [4:0] pix_r, pix_g, pix_b;

    always_comb begin
        hs         = hcnt_q < H_SYNC_W;
        vs         = vcnt_q < V_SYNC_W;
        h_act      = (hcnt_q >= H_BEG) && (hcnt_q < H_END);
        active     = h_act && (vcnt_q >= V_BEG) && (vcnt_q < V_END);
        frame_wrap = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
        x          = hcnt_q - H_BEG;
        y          = 8'(vcnt_q - V_BEG);
        // Box bounds are compared one bit wider so frame_cnt+32 never wraps.
        box        = ({1'b0, x} >= {2'b00, frame_cnt_q})
                  && ({1'b0, x} < ({2'b00, frame_cnt_q} + 10'd32))
                  && (y >= 8'd96) && (y < 8'd128);

        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (active) begin
            unique case (pat_q)
                2'd0: begin
                    pix_r = {5{~bar_q[1]}};
                    pix_g = {5{~bar_q[2]}};
                    pix_b = {5{~bar_q[0]}};
                end
                2'd1: begin
                    pix_r = x[8:4];
                    pix_g = x[8:4];
                    pix_b = x[8:4];
                end
                2'd2: begin
                    pix_r = {5{x[4] ^ y[4]}};
                    pix_g = {5{x[4] ^ y[4]}};
                    pix_b = {5{x[4] ^ y[4]}};
                end
                default: begin
                    pix_r = box ? 5'd31 : 5'd0;
                    pix_g = box ? 5'd31 : 5'd0;
                    pix_b = box ? 5'd31 : 5'd16;
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        fcnt_out_d  = fcnt_out_q;
        pat_d       = pat_q;
        bar_d       = bar_q;
        bar_px_d    = bar_px_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        dark_d      = dark_q;
        shadow_d    = shadow_q;
        csync_d     = csync_q;
        fstart_d    = 1'b0;

        if (enable) begin
            r_d        = pix_r;
            g_d        = pix_g;
            b_d        = pix_b;
            dark_d     = dark_i & active;
            shadow_d   = shadow_i & active;
            csync_d    = ~(hs ^ vs);
            fstart_d   = (hcnt_q == '0) && (vcnt_q == '0);
            fcnt_out_d = frame_cnt_q;

            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 9'd1;
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end

            if (frame_wrap) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                pat_d       = pattern_sel;
            end

            // Bar index is a 40-pixel stepping counter, re-armed just before the first active pixel.
            if (hcnt_d == H_BEG) begin
                bar_d    = '0;
                bar_px_d = '0;
            end else if (h_act) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d = '0;
                    bar_d    = bar_q + 3'd1;
                end else begin
                    bar_px_d = bar_px_q + 6'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge VCLK_i) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            fcnt_out_q  <= '0;
            pat_q       <= pattern_sel;
            bar_q       <= '0;
            bar_px_q    <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            dark_q      <= 1'b0;
            shadow_q    <= 1'b0;
            csync_q     <= 1'b1;
            fstart_q    <= 1'b0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            fcnt_out_q  <= fcnt_out_d;
            pat_q       <= pat_d;
            bar_q       <= bar_d;
            bar_px_q    <= bar_px_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            dark_q      <= dark_d;
            shadow_q    <= shadow_d;
            csync_q     <= csync_d;
            fstart_q    <= fstart_d;
        end
    end

    assign R_o           = r_q;
    assign G_o           = g_q;
    assign B_o           = b_q;
    assign DARK_o        = dark_q;
    assign SHADOW_o      = shadow_q;
    assign CSYNC_o       = csync_q;
    assign frame_start_o = fstart_q;
    assign frame_cnt_o   = fcnt_out_q;

endmodule

// File: tb/tb_neogeo_tx_gen.sv
// Three generators (full-width lines, tall box-capable frames, tiny fast frames) share stimulus
// and are compared every cycle against a raster model built from plain pixel arithmetic.
module tb_neogeo_tx_gen;
    localparam int A_HT = 384, A_HS = 29, A_HB = 60, A_HA = 320;
    localparam int A_VT = 40,  A_VS = 8,  A_VB = 24, A_VA = 16;
    localparam int B_HT = 64,  B_HS = 4,  B_HB = 8,  B_HA = 48;
    localparam int B_VT = 132, B_VS = 2,  B_VB = 2,  B_VA = 128;
    localparam int C_HT = 8,   C_HS = 2,  C_HB = 2,  C_HA = 4;
    localparam int C_VT = 4,   C_VS = 1,  C_VB = 1,  C_VA = 2;
    localparam int FB = B_HT * B_VT;
    localparam int FC = C_HT * C_VT;

    logic       clk = 1'b0;
    logic       reset, enable, dark_i, shadow_i;
    logic [1:0] pattern_sel;

    logic [4:0] r_o [3];
    logic [4:0] g_o [3];
    logic [4:0] b_o [3];
    logic       dark_o [3];
    logic       shadow_o [3];
    logic       csync_o [3];
    logic       fs_o [3];
    logic [7:0] fco_o [3];
    logic [26:0] obs [3];

    int checks = 0;
    int failures = 0;
    int p_ht[3], p_hs[3], p_hb[3], p_ha[3], p_vt[3], p_vs[3], p_vb[3], p_va[3];
    int m_h[3], m_v[3], m_fc[3], m_pat[3];
    logic [26:0] exp_v [3];

    always #5 clk = ~clk;

    neogeo_tx_gen #(.H_TOTAL(A_HT), .H_SYNC(A_HS), .H_START(A_HB), .H_ACTIVE(A_HA),
                    .V_TOTAL(A_VT), .V_SYNC(A_VS), .V_START(A_VB), .V_ACTIVE(A_VA)) dut_a (
        .VCLK_i(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .dark_i(dark_i), .shadow_i(shadow_i), .R_o(r_o[0]), .G_o(g_o[0]), .B_o(b_o[0]),
        .DARK_o(dark_o[0]), .SHADOW_o(shadow_o[0]), .CSYNC_o(csync_o[0]),
        .frame_start_o(fs_o[0]), .frame_cnt_o(fco_o[0]));

    neogeo_tx_gen #(.H_TOTAL(B_HT), .H_SYNC(B_HS), .H_START(B_HB), .H_ACTIVE(B_HA),
                    .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_START(B_VB), .V_ACTIVE(B_VA)) dut_b (
        .VCLK_i(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .dark_i(dark_i), .shadow_i(shadow_i), .R_o(r_o[1]), .G_o(g_o[1]), .B_o(b_o[1]),
        .DARK_o(dark_o[1]), .SHADOW_o(shadow_o[1]), .CSYNC_o(csync_o[1]),
        .frame_start_o(fs_o[1]), .frame_cnt_o(fco_o[1]));

    neogeo_tx_gen #(.H_TOTAL(C_HT), .H_SYNC(C_HS), .H_START(C_HB), .H_ACTIVE(C_HA),
                    .V_TOTAL(C_VT), .V_SYNC(C_VS), .V_START(C_VB), .V_ACTIVE(C_VA)) dut_c (
        .VCLK_i(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .dark_i(dark_i), .shadow_i(shadow_i), .R_o(r_o[2]), .G_o(g_o[2]), .B_o(b_o[2]),
        .DARK_o(dark_o[2]), .SHADOW_o(shadow_o[2]), .CSYNC_o(csync_o[2]),
        .frame_start_o(fs_o[2]), .frame_cnt_o(fco_o[2]));

    assign obs[0] = {r_o[0], g_o[0], b_o[0], dark_o[0], shadow_o[0], csync_o[0], fs_o[0], fco_o[0]};
    assign obs[1] = {r_o[1], g_o[1], b_o[1], dark_o[1], shadow_o[1], csync_o[1], fs_o[1], fco_o[1]};
    assign obs[2] = {r_o[2], g_o[2], b_o[2], dark_o[2], shadow_o[2], csync_o[2], fs_o[2], fco_o[2]};

    // Pixel colour and sync for raster position (h, v) straight from the pattern definitions.
    function automatic logic [17:0] model_pix(int k, int h, int v, int fc, int pat, logic dk, logic sh);
        int x, y, idx;
        logic act, hs, vs;
        logic [4:0] r, g, b;
        hs  = h < p_hs[k];
        vs  = v < p_vs[k];
        act = (h >= p_hb[k]) && (h < p_hb[k] + p_ha[k]) && (v >= p_vb[k]) && (v < p_vb[k] + p_va[k]);
        x = h - p_hb[k];
        y = v - p_vb[k];
        r = 5'd0; g = 5'd0; b = 5'd0;
        if (act) begin
            case (pat)
                0: begin
                    idx = x / 40;
                    r = (idx == 0 || idx == 1 || idx == 4 || idx == 5) ? 5'd31 : 5'd0;
                    g = (idx < 4) ? 5'd31 : 5'd0;
                    b = (idx % 2 == 0) ? 5'd31 : 5'd0;
                end
                1: begin
                    r = 5'(x / 16); g = r; b = r;
                end
                2: begin
                    r = (((x / 16) % 2) != ((y / 16) % 2)) ? 5'd31 : 5'd0; g = r; b = r;
                end
                default: begin
                    if (x >= fc && x < fc + 32 && y >= 96 && y < 128) begin
                        r = 5'd31; g = 5'd31; b = 5'd31;
                    end else begin
                        b = 5'd16;
                    end
                end
            endcase
        end
        return {r, g, b, dk & act, sh & act, ~(hs ^ vs)};
    endfunction

    task automatic model_edge(int k);
        if (reset) begin
            m_h[k] = 0; m_v[k] = 0; m_fc[k] = 0; m_pat[k] = int'(pattern_sel);
            exp_v[k] = 27'h200;
        end else if (enable) begin
            exp_v[k] = {model_pix(k, m_h[k], m_v[k], m_fc[k], m_pat[k], dark_i, shadow_i),
                        (m_h[k] == 0 && m_v[k] == 0), 8'(m_fc[k])};
            if (m_h[k] == p_ht[k] - 1 && m_v[k] == p_vt[k] - 1) begin
                m_fc[k]  = (m_fc[k] + 1) % 256;
                m_pat[k] = int'(pattern_sel);
            end
            m_h[k] = (m_h[k] + 1) % p_ht[k];
            if (m_h[k] == 0) m_v[k] = (m_v[k] + 1) % p_vt[k];
        end else begin
            exp_v[k][8] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) model_edge(k);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; pattern_sel = 2'd0; dark_i = 1'b1; shadow_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== 27'h200) begin
                    failures++;
                    $display("FAIL reset inst=%0d got=%h exp=%h", k, obs[k], 27'h200);
                end
            end
        end
    endtask

    task automatic test_bars();
        logic [14:0] want;
        bit tgt;
        reset = 1'b1; pattern_sel = 2'd0; tick(); reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < A_HT * 32; c++) begin
            dark_i = 1'($urandom_range(0, 1)); shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL bars inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
            end
            tgt = 0; want = '0;
            if (c / A_HT == 30) begin
                if (c % A_HT == A_HB)       begin tgt = 1; want = 15'h7fff; end
                if (c % A_HT == A_HB + 40)  begin tgt = 1; want = 15'h7fe0; end
                if (c % A_HT == A_HB + 280) begin tgt = 1; want = 15'h0000; end
            end
            if (tgt) begin
                checks++;
                if (obs[0][26:12] !== want) begin
                    failures++;
                    $display("FAIL bar_colour hcnt=%0d got=%h exp=%h", c % A_HT, obs[0][26:12], want);
                end
            end
        end
    endtask

    task automatic test_ramp_dark();
        logic [15:0] want;
        bit tgt;
        reset = 1'b1; pattern_sel = 2'd1; tick(); reset = 1'b0; dark_i = 1'b1;
        for (int c = 0; c < A_HT * 26; c++) begin
            shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL ramp inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
            end
            tgt = 0; want = '0;
            if (c / A_HT == 24) begin
                if (c % A_HT == A_HB - 1)  begin tgt = 1; want = {15'h0000, 1'b0}; end
                if (c % A_HT == A_HB)      begin tgt = 1; want = {15'h0000, 1'b1}; end
                if (c % A_HT == A_HB + 16) begin tgt = 1; want = {15'h0421, 1'b1}; end
                if (c % A_HT == A_HB + 319) begin tgt = 1; want = {15'h4e73, 1'b1}; end
                if (c % A_HT == A_HB + 320) begin tgt = 1; want = {15'h0000, 1'b0}; end
            end
            if (tgt) begin
                checks++;
                if (obs[0][26:11] !== want) begin
                    failures++;
                    $display("FAIL ramp_pixel hcnt=%0d got=%h exp=%h", c % A_HT, obs[0][26:11], want);
                end
            end
        end
    endtask

    task automatic test_pattern_switch();
        logic [14:0] want;
        bit tgt;
        int f, h, v;
        reset = 1'b1; pattern_sel = 2'd0; tick(); reset = 1'b0;
        for (int c = 0; c < FB + B_HT * 4; c++) begin
            if (c == FB / 2) pattern_sel = 2'd2;
            dark_i = 1'($urandom_range(0, 1)); shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL switch inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
            end
            f = c / FB; h = (c % FB) % B_HT; v = (c % FB) / B_HT;
            tgt = 0; want = '0;
            if (f == 0 && v == B_VB + 127 && h == B_HB + 40) begin tgt = 1; want = 15'h7fe0; end
            if (f == 1 && v == B_VB && h == B_HB)            begin tgt = 1; want = 15'h0000; end
            if (f == 1 && v == B_VB && h == B_HB + 16)       begin tgt = 1; want = 15'h7fff; end
            if (f == 1 && v == B_VB && h == B_HB + 40)       begin tgt = 1; want = 15'h0000; end
            if (tgt) begin
                checks++;
                if (obs[1][26:12] !== want) begin
                    failures++;
                    $display("FAIL switch_pixel frame=%0d h=%0d v=%0d got=%h exp=%h", f, h, v, obs[1][26:12], want);
                end
            end
        end
    endtask

    task automatic test_box();
        logic [14:0] want;
        bit tgt;
        int f, h, v;
        reset = 1'b1; pattern_sel = 2'd3; tick(); reset = 1'b0;
        for (int c = 0; c < 2 * FB + 2; c++) begin
            dark_i = 1'($urandom_range(0, 1)); shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL box inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
            end
            f = c / FB; h = (c % FB) % B_HT; v = (c % FB) / B_HT;
            tgt = 0; want = '0;
            if (f == 0 && v == B_VB + 127 && h == B_HB + 31) begin tgt = 1; want = 15'h7fff; end
            if (f == 0 && v == B_VB + 127 && h == B_HB + 32) begin tgt = 1; want = 15'h0010; end
            if (f == 1 && v == B_VB + 96 && h == B_HB)       begin tgt = 1; want = 15'h0010; end
            if (f == 1 && v == B_VB + 96 && h == B_HB + 1)   begin tgt = 1; want = 15'h7fff; end
            if (f == 1 && v == B_VB + 96 && h == B_HB + 32)  begin tgt = 1; want = 15'h7fff; end
            if (f == 1 && v == B_VB + 96 && h == B_HB + 33)  begin tgt = 1; want = 15'h0010; end
            if (f == 1 && v == B_VB + 95 && h == B_HB + 5)   begin tgt = 1; want = 15'h0010; end
            if (tgt) begin
                checks++;
                if (obs[1][26:12] !== want) begin
                    failures++;
                    $display("FAIL box_pixel frame=%0d h=%0d v=%0d got=%h exp=%h", f, h, v, obs[1][26:12], want);
                end
            end
            if (c == FB) begin
                checks++;
                if (obs[1][8:0] !== 9'h101) begin
                    failures++;
                    $display("FAIL box_frame_start got=%h exp=%h", obs[1][8:0], 9'h101);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 260 * FC; c++) begin
            pattern_sel = 2'($urandom_range(0, 3));
            dark_i = 1'($urandom_range(0, 1)); shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL wrap inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
            end
            checks++;
            if (obs[2][8] !== (c % FC == 0)) begin
                failures++;
                $display("FAIL frame_period cyc=%0d got=%b exp=%b", c, obs[2][8], (c % FC == 0));
            end
            if (c == 255 * FC || c == 256 * FC) begin
                checks++;
                if (obs[2][8:0] !== ((c == 255 * FC) ? 9'h1ff : 9'h100)) begin
                    failures++;
                    $display("FAIL frame_cnt_wrap cyc=%0d got=%h", c, obs[2][8:0]);
                end
            end
        end
    endtask

    task automatic test_freeze_reset();
        reset = 1'b1; pattern_sel = 2'd0; enable = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 1900; c++) begin
            if (c < 500)       enable = 1'b1;
            else if (c < 1500) enable = 1'b0;
            else               enable = ($urandom_range(0, 3) != 0);
            dark_i = 1'($urandom_range(0, 1)); shadow_i = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL freeze inst=%0d cyc=%0d en=%b got=%h exp=%h", k, c, enable, obs[k], exp_v[k]);
                end
            end
        end
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd1; tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 27'h200) begin
                failures++;
                $display("FAIL midframe_reset inst=%0d got=%h exp=%h", k, obs[k], 27'h200);
            end
        end
        reset = 1'b0; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL resume inst=%0d cyc=%0d got=%h exp=%h", k, c, obs[k], exp_v[k]);
                end
                if (c == 0) begin
                    checks++;
                    if (obs[k][9:8] !== 2'b11) begin
                        failures++;
                        $display("FAIL resume_frame_start inst=%0d got=%b exp=%b", k, obs[k][9:8], 2'b11);
                    end
                end
            end
        end
    endtask

    initial begin
        p_ht = '{A_HT, B_HT, C_HT}; p_hs = '{A_HS, B_HS, C_HS};
        p_hb = '{A_HB, B_HB, C_HB}; p_ha = '{A_HA, B_HA, C_HA};
        p_vt = '{A_VT, B_VT, C_VT}; p_vs = '{A_VS, B_VS, C_VS};
        p_vb = '{A_VB, B_VB, C_VB}; p_va = '{A_VA, B_VA, C_VA};
        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; dark_i = 1'b0; shadow_i = 1'b0;
        test_reset();
        test_bars();
        test_ramp_dark();
        test_pattern_switch();
        test_box();
        test_frame_wrap();
        test_freeze_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
